// File: rtl/axil_tg_pkg.sv
// Shared types for the AXI4-Lite traffic generator: run modes, FSM states, response codes.
package axil_tg_pkg;

    typedef enum logic [1:0] {TG_READ, TG_WRITE, TG_WRB, TG_RSVD} mode_t;

    typedef enum logic [2:0] {IDLE, AR, R, AW_W, B, NEXT, DONE} state_t;

    localparam logic [1:0] RESP_OKAY = 2'b00;

endpackage

// File: rtl/axil_tg_addr_seq.sv
// Address/index sequencer: walks base..lim in ADDR_STEP increments, wrapping to base,
// and flags the last transaction of the run.
module axil_tg_addr_seq #(
    parameter int ADDR_W    = 24,
    parameter int CNT_W     = 16,
    parameter int ADDR_STEP = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              step,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] lim_addr,
    input  logic [CNT_W-1:0]  num_xfer,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);

    logic [ADDR_W-1:0] addr_q, addr_d, base_q, base_d, lim_q, lim_d;
    logic [CNT_W-1:0]  idx_q, idx_d, num_q, num_d;
    logic [ADDR_W:0]   sum;

    always_comb begin
        // One extra bit so a step past 2^ADDR_W also lands above lim and wraps.
        sum    = {1'b0, addr_q} + (ADDR_W+1)'(ADDR_STEP);
        addr_d = addr_q;
        idx_d  = idx_q;
        base_d = base_q;
        lim_d  = lim_q;
        num_d  = num_q;
        if (load) begin
            addr_d = base_addr;
            idx_d  = '0;
            base_d = base_addr;
            lim_d  = lim_addr;
            num_d  = num_xfer;
        end else if (step) begin
            idx_d  = idx_q + CNT_W'(1);
            addr_d = (sum > {1'b0, lim_q}) ? base_q : sum[ADDR_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q <= '0;
            idx_q  <= '0;
            base_q <= '0;
            lim_q  <= '0;
            num_q  <= '0;
        end else begin
            addr_q <= addr_d;
            idx_q  <= idx_d;
            base_q <= base_d;
            lim_q  <= lim_d;
            num_q  <= num_d;
        end
    end

    assign addr = addr_q;
    assign last = (({1'b0, idx_q} + (CNT_W+1)'(1)) == {1'b0, num_q});

endmodule

// File: rtl/axil_master_traffic_gen.sv
// AXI4-Lite master traffic generator/checker: read, write or write-then-readback runs
// over an address window, with pattern check, error/timeout statistics.
//   IDLE wait for start | AR/R read addr/data | AW_W/B write addr+data/resp
//   NEXT advance index/addr | DONE one-cycle done pulse
module axil_master_traffic_gen
    import axil_tg_pkg::*;
#(
    parameter int ADDR_W    = 24,
    parameter int DATA_W    = 32,
    parameter int CNT_W     = 16,
    parameter int ADDR_STEP = 1,
    parameter int TIMEOUT   = 255
) (
    input  logic                ACLK,
    input  logic                ARESET,
    input  logic                start,
    input  logic [1:0]          mode,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [ADDR_W-1:0]   lim_addr,
    input  logic [CNT_W-1:0]    num_xfer,
    input  logic [DATA_W-1:0]   seed,
    output logic                busy,
    output logic                done,
    output logic [CNT_W-1:0]    err_cnt,
    output logic [CNT_W-1:0]    mism_cnt,
    output logic [CNT_W-1:0]    tout_cnt,
    output logic [ADDR_W-1:0]   araddr,
    output logic                arvalid,
    input  logic                arready,
    input  logic [DATA_W-1:0]   rdata,
    input  logic [1:0]          rresp,
    input  logic                rvalid,
    output logic                rready,
    output logic [ADDR_W-1:0]   awaddr,
    output logic                awvalid,
    input  logic                awready,
    output logic [DATA_W-1:0]   wdata,
    output logic [DATA_W/8-1:0] wstrb,
    output logic                wvalid,
    input  logic                wready,
    input  logic [1:0]          bresp,
    input  logic                bvalid,
    output logic                bready
);

    localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT - 1);

    state_t              state_q, state_d;
    mode_t               mode_q, mode_d, start_mode;
    logic [DATA_W-1:0]   seed_q, seed_d, pattern;
    logic [TMR_W-1:0]    tmr_q, tmr_d;
    logic [CNT_W-1:0]    err_q, err_d, mism_q, mism_d, tout_q, tout_d;
    logic                arvalid_q, arvalid_d, rready_q, rready_d, awvalid_q, awvalid_d;
    logic                wvalid_q, wvalid_d, bready_q, bready_d, busy_q, busy_d, done_q, done_d;
    logic                seq_load, seq_step, seq_last, run_wr, start_wr, expired;
    logic [ADDR_W-1:0]   seq_addr;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    axil_tg_addr_seq #(.ADDR_W(ADDR_W), .CNT_W(CNT_W), .ADDR_STEP(ADDR_STEP)) u_seq (
        .clk(ACLK), .rst(ARESET), .load(seq_load), .step(seq_step),
        .base_addr(base_addr), .lim_addr(lim_addr), .num_xfer(num_xfer),
        .addr(seq_addr), .last(seq_last)
    );

    assign start_mode = mode_t'(mode);
    assign start_wr   = (start_mode == TG_WRITE) || (start_mode == TG_WRB);
    assign run_wr     = (mode_q == TG_WRITE) || (mode_q == TG_WRB);
    assign pattern    = seed_q ^ DATA_W'(seq_addr);
    assign expired    = (tmr_q == '0);

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        seed_d    = seed_q;
        arvalid_d = arvalid_q;
        rready_d  = rready_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        bready_d  = bready_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        err_d     = err_q;
        mism_d    = mism_q;
        tout_d    = tout_q;
        seq_load  = 1'b0;
        seq_step  = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                mode_d   = start_mode;
                seed_d   = seed;
                seq_load = 1'b1;
                busy_d   = 1'b1;
                err_d    = '0;
                mism_d   = '0;
                tout_d   = '0;
                if (num_xfer == '0) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end else if (start_wr) begin
                    state_d   = AW_W;
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                end else begin
                    state_d   = AR;
                    arvalid_d = 1'b1;
                end
            end
            AR: if (arready) begin
                arvalid_d = 1'b0;
                rready_d  = 1'b1;
                state_d   = R;
            end else if (expired) begin
                state_d = NEXT;
            end
            R: if (rvalid) begin
                rready_d = 1'b0;
                if (rresp != RESP_OKAY) err_d = sat_inc(err_q);
                if (mode_q == TG_WRB && rdata != pattern) mism_d = sat_inc(mism_q);
                state_d = NEXT;
            end else if (expired) begin
                state_d = NEXT;
            end
            AW_W: begin
                if (awready) awvalid_d = 1'b0;
                if (wready) wvalid_d = 1'b0;
                if (!awvalid_d && !wvalid_d) begin
                    bready_d = 1'b1;
                    state_d  = B;
                end else if (expired) begin
                    state_d = NEXT;
                end
            end
            B: if (bvalid) begin
                bready_d = 1'b0;
                if (bresp != RESP_OKAY) err_d = sat_inc(err_q);
                if (mode_q == TG_WRB) begin
                    state_d   = AR;
                    arvalid_d = 1'b1;
                end else begin
                    state_d = NEXT;
                end
            end else if (expired) begin
                state_d = NEXT;
            end
            NEXT: if (seq_last) begin
                state_d = DONE;
                done_d  = 1'b1;
                busy_d  = 1'b0;
            end else begin
                seq_step = 1'b1;
                if (run_wr) begin
                    state_d   = AW_W;
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                end else begin
                    state_d   = AR;
                    arvalid_d = 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // A phase that leaves for NEXT from a wait state without completing is a timeout.
        if (state_d == NEXT && state_q != NEXT && state_q != R && !(state_q == B && bvalid)) begin
            arvalid_d = 1'b0;
            rready_d  = 1'b0;
            awvalid_d = 1'b0;
            wvalid_d  = 1'b0;
            bready_d  = 1'b0;
            tout_d    = sat_inc(tout_q);
        end else if (state_q == R && !rvalid && state_d == NEXT) begin
            rready_d = 1'b0;
            tout_d   = sat_inc(tout_q);
        end

        if (state_d != state_q)  tmr_d = TMR_LOAD;
        else if (tmr_q != '0)    tmr_d = tmr_q - TMR_W'(1);
        else                     tmr_d = tmr_q;
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q   <= IDLE;
            mode_q    <= TG_READ;
            seed_q    <= '0;
            tmr_q     <= '0;
            err_q     <= '0;
            mism_q    <= '0;
            tout_q    <= '0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            seed_q    <= seed_d;
            tmr_q     <= tmr_d;
            err_q     <= err_d;
            mism_q    <= mism_d;
            tout_q    <= tout_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            bready_q  <= bready_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign err_cnt  = err_q;
    assign mism_cnt = mism_q;
    assign tout_cnt = tout_q;
    assign araddr   = seq_addr;
    assign arvalid  = arvalid_q;
    assign rready   = rready_q;
    assign awaddr   = seq_addr;
    assign awvalid  = awvalid_q;
    assign wdata    = pattern;
    assign wstrb    = {(DATA_W/8){1'b1}};
    assign wvalid   = wvalid_q;
    assign bready   = bready_q;

endmodule

// File: tb/tb_axil_master_traffic_gen.sv
// Directed bench for axil_master_traffic_gen with a small reactive AXI4-Lite slave model.
module tb_axil_master_traffic_gen;

    localparam int ADDR_W = 24;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 16;

    logic              ACLK = 1'b0;
    logic              ARESET = 1'b1;
    logic              start = 1'b0;
    logic [1:0]        mode = 2'd0;
    logic [ADDR_W-1:0] base_addr = '0, lim_addr = '0;
    logic [CNT_W-1:0]  num_xfer = '0;
    logic [DATA_W-1:0] seed = '0;
    logic              busy, done;
    logic [CNT_W-1:0]  err_cnt, mism_cnt, tout_cnt;
    logic [ADDR_W-1:0] araddr, awaddr;
    logic              arvalid, arready, rvalid, rready, awvalid, awready, wvalid, wready, bvalid, bready;
    logic [DATA_W-1:0] rdata, wdata;
    logic [1:0]        rresp, bresp;
    logic [3:0]        wstrb;

    // slave knobs and model state
    logic              ar_en = 1'b1, r_en = 1'b1, flip_en = 1'b0;
    logic [ADDR_W-1:0] flip_addr = 24'h000012;
    int                wdelay = 0, wv_cnt = 0, b_cnt = 0, berr_idx = -1;
    logic [DATA_W-1:0] mem [16];

    // monitor state
    logic [ADDR_W-1:0] ar_log [$];
    logic [DATA_W-1:0] w_log [$];
    int                ar_hi, aw_hi, w_hi, done_cnt;
    logic              done_now, w_wait, b_hs;

    int n_chk = 0;
    int n_err = 0;
    int cycles;

    always #5 ACLK = ~ACLK;

    assign arready = ar_en;
    assign rvalid  = r_en;
    assign rresp   = 2'b00;
    assign rdata   = mem[araddr[3:0]] ^ ((flip_en && araddr == flip_addr) ? 32'h0000_0100 : 32'h0);
    assign awready = 1'b1;
    assign wready  = (wv_cnt >= wdelay);
    assign bvalid  = 1'b1;
    assign bresp   = (b_cnt == berr_idx) ? 2'b10 : 2'b00;

    axil_master_traffic_gen #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W), .ADDR_STEP(1), .TIMEOUT(255)
    ) dut (
        .ACLK(ACLK), .ARESET(ARESET), .start(start), .mode(mode),
        .base_addr(base_addr), .lim_addr(lim_addr), .num_xfer(num_xfer), .seed(seed),
        .busy(busy), .done(done), .err_cnt(err_cnt), .mism_cnt(mism_cnt), .tout_cnt(tout_cnt),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One clock: observe mid-cycle, then advance the slave model just after the edge.
    task automatic cyc();
        @(negedge ACLK);
        if (arvalid) ar_hi++;
        if (awvalid) aw_hi++;
        if (wvalid)  w_hi++;
        done_now = done;
        if (done) done_cnt++;
        if (arvalid && arready) ar_log.push_back(araddr);
        if (wvalid && wready) begin
            w_log.push_back(wdata);
            mem[awaddr[3:0]] = wdata;
        end
        w_wait = wvalid && !wready;
        b_hs   = bvalid && bready;
        @(posedge ACLK);
        #1;
        wv_cnt = w_wait ? wv_cnt + 1 : 0;
        if (b_hs) b_cnt++;
    endtask

    task automatic clr_mon();
        ar_log.delete();
        w_log.delete();
        ar_hi = 0; aw_hi = 0; w_hi = 0; done_cnt = 0; b_cnt = 0; wv_cnt = 0;
    endtask

    // Launch a run and wait for done; cycles = clocks from the start edge to the done cycle.
    task automatic run(input string tag, input logic [1:0] m, input logic [ADDR_W-1:0] b,
                       input logic [ADDR_W-1:0] l, input logic [CNT_W-1:0] n,
                       input logic [DATA_W-1:0] s, input int max_cyc, output int cyc_out);
        clr_mon();
        mode = m; base_addr = b; lim_addr = l; num_xfer = n; seed = s;
        start = 1'b1;
        cyc();
        start = 1'b0;
        cyc_out = 0;
        for (int i = 1; i <= max_cyc; i++) begin
            cyc();
            if (done_now) begin
                cyc_out = i;
                break;
            end
        end
        chk({tag, "_done_seen"}, 64'(cyc_out != 0), 64'd1);
        cyc();
        chk({tag, "_done_pulse"}, 64'(done_cnt), 64'd1);
    endtask

    logic [ADDR_W-1:0] exp1 [10];
    logic [ADDR_W-1:0] exp6 [5];

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = '0;
        exp1 = '{24'hAB0B9, 24'hAB0BA, 24'hAB0BB, 24'hAB0BC, 24'hAB0BD,
                 24'hAB0BE, 24'hAB0BF, 24'hAB0B9, 24'hAB0BA, 24'hAB0BB};
        exp6 = '{24'hFFFFFE, 24'hFFFFFF, 24'hFFFFFE, 24'hFFFFFF, 24'hFFFFFE};

        // reset state
        repeat (3) cyc();
        chk("rst_busy_done", {busy, done}, 2'b00);
        chk("rst_valids", {arvalid, rready, awvalid, wvalid, bready}, 5'b0);
        chk("rst_addr", {araddr, awaddr}, 48'h0);
        chk("rst_cnts", {err_cnt, mism_cnt, tout_cnt}, 48'h0);
        ARESET = 1'b0;
        cyc();

        // 1: read sweep with wrap, zero-wait slave; 3 cycles per transfer
        run("t1", 2'd0, 24'hAB0B9, 24'hAB0BF, 16'd10, 32'h0, 100, cycles);
        chk("t1_cycles", 64'(cycles), 64'd31);
        chk("t1_nar", 64'(ar_log.size()), 64'd10);
        for (int i = 0; i < 10; i++) chk($sformatf("t1_addr%0d", i), 64'(ar_log[i]), 64'(exp1[i]));
        chk("t1_err", 64'(err_cnt), 64'd0);

        // 2: write-readback against a memory slave; 5 cycles per transfer
        run("t2", 2'd2, 24'h000010, 24'h00001F, 16'd4, 32'hDEADBEEF, 100, cycles);
        chk("t2_cycles", 64'(cycles), 64'd21);
        chk("t2_nw", 64'(w_log.size()), 64'd4);
        chk("t2_w0", 64'(w_log[0]), 64'hDEADBEFF);
        chk("t2_w1", 64'(w_log[1]), 64'hDEADBEFE);
        chk("t2_w2", 64'(w_log[2]), 64'hDEADBEFD);
        chk("t2_w3", 64'(w_log[3]), 64'hDEADBEFC);
        chk("t2_wstrb", 64'(wstrb), 64'hF);
        chk("t2_mism", 64'(mism_cnt), 64'd0);
        chk("t2_err", 64'(err_cnt), 64'd0);
        flip_en = 1'b1;
        run("t2f", 2'd2, 24'h000010, 24'h00001F, 16'd4, 32'hDEADBEEF, 100, cycles);
        chk("t2f_mism", 64'(mism_cnt), 64'd1);
        flip_en = 1'b0;

        // 3: write with wready 3 cycles behind awready, SLVERR on 2nd response
        wdelay = 3; berr_idx = 1;
        run("t3", 2'd1, 24'h000020, 24'h00002F, 16'd2, 32'h12345678, 100, cycles);
        chk("t3_cycles", 64'(cycles), 64'd13);
        chk("t3_aw_hi", 64'(aw_hi), 64'd2);
        chk("t3_w_hi", 64'(w_hi), 64'd8);
        chk("t3_w0", 64'(w_log[0]), 64'h12345658);
        chk("t3_w1", 64'(w_log[1]), 64'h12345659);
        chk("t3_err", 64'(err_cnt), 64'd1);
        wdelay = 0; berr_idx = -1;

        // 4: arready never comes; each transfer times out after 255 cycles
        ar_en = 1'b0;
        run("t4", 2'd0, 24'h000030, 24'h00003F, 16'd2, 32'h0, 1000, cycles);
        chk("t4_cycles", 64'(cycles), 64'd513);
        chk("t4_ar_hi", 64'(ar_hi), 64'd510);
        chk("t4_tout", 64'(tout_cnt), 64'd2);
        ar_en = 1'b1;
        ARESET = 1'b1;
        cyc();
        chk("t4_rst_tout", 64'(tout_cnt), 64'd0);
        ARESET = 1'b0;
        cyc();

        // 6: window at the top of the address space wraps without overflow
        run("t6", 2'd0, 24'hFFFFFE, 24'hFFFFFF, 16'd5, 32'h0, 100, cycles);
        chk("t6_cycles", 64'(cycles), 64'd16);
        for (int i = 0; i < 5; i++) chk($sformatf("t6_addr%0d", i), 64'(ar_log[i]), 64'(exp6[i]));

        // 5: reset while waiting in R with rvalid pending
        r_en = 1'b0;
        clr_mon();
        mode = 2'd0; base_addr = 24'h000040; lim_addr = 24'h00004F; num_xfer = 16'd3;
        start = 1'b1;
        cyc();
        start = 1'b0;
        cyc();
        cyc();
        chk("t5_pre_rready", {rready, busy}, 2'b11);
        ARESET = 1'b1;
        cyc();
        chk("t5_rst_rdy_busy", {rready, busy, arvalid}, 3'b000);
        chk("t5_rst_addr", 64'(araddr), 64'h0);
        ARESET = 1'b0;
        r_en = 1'b1;
        cyc();

        // 5: start while busy is ignored
        clr_mon();
        mode = 2'd0; base_addr = 24'h000050; lim_addr = 24'h00005F; num_xfer = 16'd2;
        start = 1'b1;
        cyc();
        start = 1'b0;
        cyc();
        num_xfer = 16'd0; base_addr = 24'h000070;
        start = 1'b1;
        cyc();
        start = 1'b0;
        repeat (20) cyc();
        chk("t5_busy_nar", 64'(ar_log.size()), 64'd2);
        chk("t5_busy_addr1", 64'(ar_log[1]), 64'h51);
        chk("t5_busy_done", 64'(done_cnt), 64'd1);

        // 5: zero-length run finishes one cycle after start
        run("t5z", 2'd0, 24'h000000, 24'h00000F, 16'd0, 32'h0, 10, cycles);
        chk("t5z_cycles", 64'(cycles), 64'd1);
        chk("t5z_nar", 64'(ar_log.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
